// File: rtl/array_extreme_scanner_pkg.sv
// Shared definitions for the array extreme scanner: FSM encoding and default element stride.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package array_extreme_scanner_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Byte stride between consecutive 32-bit words in data memory.
    localparam int DEFAULT_WORD_BYTES = 4;

endpackage

// File: rtl/array_extreme_scanner_compare.sv
// Decides whether a candidate word replaces the current extreme (strict compare, so ties keep the older entry).
// Latency: purely combinational.
// Backpressure: none.
// Ports: candidate/current words in, signed_mode selects two's-complement, find_min selects direction, take out.
module extreme_compare #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] candidate,
    input  logic [DATA_WIDTH-1:0] current,
    input  logic                  signed_mode,
    input  logic                  find_min,
    output logic                  take
);

    logic greater;
    logic less;

    always_comb begin
        greater = 1'b0;
        less    = 1'b0;
        if (signed_mode) begin
            greater = $signed(candidate) > $signed(current);
            less    = $signed(candidate) < $signed(current);
        end else begin
            greater = candidate > current;
            less    = candidate < current;
        end
        take = find_min ? less : greater;
    end

endmodule

// File: rtl/array_extreme_scanner.sv
// Walks count words from base_addr through an async-read memory port and reports the max/min value and its index.
// Latency: start at edge t -> one element per cycle over t+1..t+count -> done pulse in cycle t+count+1 (t+1 if count==0).
// Backpressure: none; memory must answer in the same cycle, start is ignored unless IDLE.
// Ports: clk/rst (sync, active-high); start/base_addr/count/signed_mode/find_min captured on start;
//        mem_read/mem_addr/mem_read_data form the read master; busy/done/empty/max_value/max_index report status.
module array_extreme_scanner
    import array_extreme_scanner_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  signed_mode,
    input  logic                  find_min,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] max_value,
    output logic [CNT_WIDTH-1:0]  max_index
);

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  signed_q;
    logic                  min_q;
    logic [CNT_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] work_val;
    logic [CNT_WIDTH-1:0]  work_idx;

    logic                  take_cmp;
    logic                  take;
    logic                  last_elem;
    logic [DATA_WIDTH-1:0] val_nxt;
    logic [CNT_WIDTH-1:0]  idx_nxt;

    extreme_compare #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_compare (
        .candidate   (mem_read_data),
        .current     (work_val),
        .signed_mode (signed_q),
        .find_min    (min_q),
        .take        (take_cmp)
    );

    // cnt_q is nonzero whenever we are in SCAN, so count-1 never underflows there.
    assign last_elem = (idx == cnt_q - CNT_WIDTH'(1));

    // Element 0 seeds the working pair regardless of its value.
    assign take    = (idx == '0) || take_cmp;
    assign val_nxt = take ? mem_read_data : work_val;
    assign idx_nxt = take ? idx : work_idx;

    // Status and memory-port outputs derive only from registered state.
    assign busy     = (state == S_SCAN);
    assign mem_read = (state == S_SCAN);
    assign done     = (state == S_DONE);
    assign mem_addr = (state == S_SCAN)
                    ? base_q + ADDR_WIDTH'(idx) * ADDR_WIDTH'(WORD_BYTES)
                    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (count != '0) ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                if (last_elem) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            min_q     <= 1'b0;
            idx       <= '0;
            work_val  <= '0;
            work_idx  <= '0;
            empty     <= 1'b0;
            max_value <= '0;
            max_index <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        cnt_q    <= count;
                        signed_q <= signed_mode;
                        min_q    <= find_min;
                        idx      <= '0;
                        if (count == '0) begin
                            empty     <= 1'b1;
                            max_value <= '0;
                            max_index <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    work_val <= val_nxt;
                    work_idx <= idx_nxt;
                    if (last_elem) begin
                        // Publish straight from the compare result so the final element counts.
                        empty     <= 1'b0;
                        max_value <= val_nxt;
                        max_index <= idx_nxt;
                    end else begin
                        idx <= idx + CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_extreme_scanner.sv
// Testbench for array_extreme_scanner: directed scans with a result/address scoreboard and an independent monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_array_extreme_scanner;

    typedef struct {
        logic [31:0] val;
        logic [15:0] idx;
        logic        emp;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] count;
    logic        signed_mode;
    logic        find_min;
    logic [31:0] mem_read_data;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        busy;
    logic        done;
    logic        empty;
    logic [31:0] max_value;
    logic [15:0] max_index;

    logic [31:0] mem [16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    exp_t        res_q[$];
    logic [31:0] addr_q[$];

    array_extreme_scanner dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .count         (count),
        .signed_mode   (signed_mode),
        .find_min      (find_min),
        .mem_read_data (mem_read_data),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .busy          (busy),
        .done          (done),
        .empty         (empty),
        .max_value     (max_value),
        .max_index     (max_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Small async-read memory aliased on address bits [5:2].
    assign mem_read_data = mem[mem_addr[5:2]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Monitor: pops expected addresses on each read and expected results on each done.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        chk("busy_eq_read", 64'(busy), 64'(mem_read));
        if (mem_read === 1'b1) begin
            if (addr_q.size() == 0) begin
                chk("unexpected_read_addr", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                a = addr_q.pop_front();
                chk("mem_addr", 64'(mem_addr), 64'(a));
            end
        end
        if (done === 1'b1) begin
            if (res_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = res_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("max_value", 64'(max_value), 64'(e.val));
                chk("max_index", 64'(max_index), 64'(e.idx));
                chk("empty", 64'(empty), 64'(e.emp));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_mem_read"},  64'(mem_read),  64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
        chk({tag, "_empty"},     64'(empty),     64'd0);
        chk({tag, "_max_value"}, 64'(max_value), 64'd0);
        chk({tag, "_max_index"}, 64'(max_index), 64'd0);
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    endtask

    task automatic push_scan(input logic [31:0] b, input logic [15:0] c);
        for (int i = 0; i < int'(c); i++) addr_q.push_back(b + 32'(i) * 32'd4);
    endtask

    task automatic wait_drain(input string tag);
        n_checks++;
        if (res_q.size() != 0 || addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: pending results %0d addresses %0d, required 0 and 0",
                     tag, res_q.size(), addr_q.size());
            res_q.delete();
            addr_q.delete();
        end
    endtask

    task automatic run_scan(input string tag, input logic [31:0] b, input logic [15:0] c,
                            input logic s, input logic m,
                            input logic [31:0] ev, input logic [15:0] ei, input logic ee);
        exp_t e;
        @(negedge clk);
        base_addr = b; count = c; signed_mode = s; find_min = m; start = 1'b1;
        e.val = ev; e.idx = ei; e.emp = ee; e.cyc = cyc + int'(c) + 1;
        res_q.push_back(e);
        push_scan(b, c);
        @(negedge clk);
        start = 1'b0;
        repeat (int'(c) + 3) @(negedge clk);
        wait_drain(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; signed_mode = 1'b0; find_min = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // 1. Unsigned max / min with a tie on 9 (lowest index wins).
        mem[0] = 32'd5; mem[1] = 32'd9; mem[2] = 32'd3; mem[3] = 32'd9; mem[4] = 32'd1;
        run_scan("umax", 32'h100, 16'd5, 1'b0, 1'b0, 32'd9, 16'd1, 1'b0);
        chk("result_hold_idle", 64'(max_value), 64'd9);
        run_scan("umin", 32'h100, 16'd5, 1'b0, 1'b1, 32'd1, 16'd4, 1'b0);

        // 2. Signed versus unsigned interpretation.
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd2; mem[2] = 32'h8000_0000;
        run_scan("smax", 32'h0, 16'd3, 1'b1, 1'b0, 32'd2,          16'd1, 1'b0);
        run_scan("umax2", 32'h0, 16'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 16'd0, 1'b0);
        run_scan("smin", 32'h0, 16'd3, 1'b1, 1'b1, 32'h8000_0000, 16'd2, 1'b0);
        run_scan("umin2", 32'h0, 16'd3, 1'b0, 1'b1, 32'd2,         16'd1, 1'b0);

        // 3. Empty scan; result stays flagged empty in IDLE.
        run_scan("empty", 32'h40, 16'd0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b1);
        chk("empty_hold", 64'(empty), 64'd1);

        // 4. Start pulses during SCAN and in the DONE cycle must be ignored.
        mem[0] = 32'd5; mem[1] = 32'd9; mem[2] = 32'd3; mem[3] = 32'd9; mem[4] = 32'd1;
        @(negedge clk);
        base_addr = 32'h100; count = 16'd5; signed_mode = 1'b0; find_min = 1'b0; start = 1'b1;
        e.val = 32'd9; e.idx = 16'd1; e.emp = 1'b0; e.cyc = cyc + 6;
        res_q.push_back(e);
        push_scan(32'h100, 16'd5);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start     = (k == 2 || k == 3 || k == 6);
            base_addr = 32'h200;
            count     = 16'd0;
            find_min  = 1'b1;
        end
        repeat (3) @(negedge clk);
        wait_drain("nostart");
        chk("nostart_idle_busy", 64'(busy), 64'd0);
        chk("nostart_result", 64'(max_value), 64'd9);

        // 5. Reset during element 2 of 5 aborts without a done pulse.
        base_addr = 32'h100; count = 16'd5; signed_mode = 1'b0; find_min = 1'b0; start = 1'b1;
        push_scan(32'h100, 16'd5);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b0;
        addr_q.delete();
        repeat (2) @(negedge clk);
        run_scan("after_abort", 32'h100, 16'd5, 1'b0, 1'b1, 32'd1, 16'd4, 1'b0);

        // 6. Address wrap past the top of the address space.
        mem[14] = 32'd7; mem[15] = 32'd7; mem[0] = 32'd2; mem[1] = 32'd8;
        run_scan("wrap_max", 32'hFFFF_FFF8, 16'd4, 1'b0, 1'b0, 32'd8, 16'd3, 1'b0);
        run_scan("wrap_min", 32'hFFFF_FFF8, 16'd4, 1'b1, 1'b1, 32'd2, 16'd2, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
